antirrebote: RTL



---
 rtl/antirrebote.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/antirrebote.sv
// -----------------------------------------------------------------------------
// antirrebote -- push-button / switch debouncer
//
// Purpose:
//   A two-flop synchroniser brings the raw, bouncing pin onto clk. A
//   four-state counter FSM then changes the clean output level only after the
//   synchronised input has held the new level for CICLOS_ESTABLE+1
//   consecutive samples. The output is a flop, so the downstream one-shot
//   stage sees a glitch-free level.
//
// Parameters:
//   CICLOS_ESTABLE  consecutive synchronised samples, beyond the first, that
//                   the input must hold before out changes (>= 1).
//
// Ports:
//   clk      in   1  system clock, rising-edge active
//   rst_n    in   1  asynchronous active-low reset
//   inp      in   1  raw asynchronous pin level
//   out      out  1  debounced level (registered)
//   rebotes  out  8  saturating count of aborted transitions
//                    (only when ANTIRREBOTE_CONTADOR_EN is defined)
//
// Optional feature macro: ANTIRREBOTE_CONTADOR_EN
// -----------------------------------------------------------------------------
module antirrebote #(
    parameter int CICLOS_ESTABLE = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inp,
    output logic       out
`ifdef ANTIRREBOTE_CONTADOR_EN
    ,
    output logic [7:0] rebotes
`endif
);

    localparam int CW = $clog2(CICLOS_ESTABLE) + 1;
    localparam logic [CW-1:0] CNT_FIN = CW'(CICLOS_ESTABLE - 1);

    typedef enum logic [1:0] {
        ESTABLE_BAJO  = 2'b00,
        CONTANDO_ALTO = 2'b01,
        ESTABLE_ALTO  = 2'b10,
        CONTANDO_BAJO = 2'b11
    } estado_t;

    logic          ff1_q, ff2_q;
    logic          inp_s;
    estado_t       estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;

    // ------------------------------------------------------------------
    // Two-flop synchroniser; the FSM only ever looks at inp_s.
    // ------------------------------------------------------------------
    // NOTE: non-blocking assignments let ff2 take ff1's old value on the
    // same edge; blocking here would collapse the chain into one flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= inp;
            ff2_q <= ff1_q;
        end
    end

    assign inp_s = ff2_q;

    // ------------------------------------------------------------------
    // FSM state, counter and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= ESTABLE_BAJO;
            cnt_q    <= '0;
            out_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. In the counting states the mismatch (abort) test
    // comes before the completion test, so the final edge must still see
    // the new level.
    // ------------------------------------------------------------------
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        case (estado_q)
            ESTABLE_BAJO: begin
                out_d = 1'b0;
                if (inp_s) begin
                    estado_d = CONTANDO_ALTO;
                    cnt_d    = '0;
                end
            end
            CONTANDO_ALTO: begin
                out_d = 1'b0;
                if (!inp_s) begin
                    estado_d = ESTABLE_BAJO;
                end else if (cnt_q == CNT_FIN) begin
                    estado_d = ESTABLE_ALTO;
                    out_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ESTABLE_ALTO: begin
                out_d = 1'b1;
                if (!inp_s) begin
                    estado_d = CONTANDO_BAJO;
                    cnt_d    = '0;
                end
            end
            CONTANDO_BAJO: begin
                out_d = 1'b1;
                if (inp_s) begin
                    estado_d = ESTABLE_ALTO;
                end else if (cnt_q == CNT_FIN) begin
                    estado_d = ESTABLE_BAJO;
                    out_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                // Unreachable with a full 2-bit encoding; kept as a safe exit.
                estado_d = ESTABLE_BAJO;
                out_d    = 1'b0;
            end
        endcase
    end

    assign out = out_q;

`ifdef ANTIRREBOTE_CONTADOR_EN
    // ------------------------------------------------------------------
    // Diagnostic bounce counter: one count per aborted transition,
    // saturating at 255, cleared only by reset.
    // ------------------------------------------------------------------
    logic       aborto;
    logic [7:0] rebotes_q;

    assign aborto = ((estado_q == CONTANDO_ALTO) && !inp_s) ||
                    ((estado_q == CONTANDO_BAJO) &&  inp_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rebotes_q <= 8'd0;
        end else if (aborto && (rebotes_q != 8'hFF)) begin
            rebotes_q <= rebotes_q + 8'd1;
        end
    end

    assign rebotes = rebotes_q;
`endif

endmodule
